mult3_top: RTL and testbench
============================

Name: mult3_top

Overview:
- Self-contained fixed-function engine: reads three 8-bit operands a, b, c from internal data memory, computes p = a*b*c modulo 2^16, writes p back to memory and raises done.
- Top level of the program-1 build.
- Operands are preloaded into memory by the bench through hierarchy while reset is asserted; the result is read back through hierarchy.

Parameters:
- DW, 8, data/operand width in bits.
- AW, 8, data memory address width (2^AW words).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- done  output  1  high when the result is stored; stays high until the next reset.

Behaviour:
- Data memory:
  - Instance dm1 of data_mem; storage array my_memory [2^AW] x DW, hierarchically writable by the bench.
  - Combinational read, synchronous write.
  - Never cleared by reset; contents persist across resets.
- Memory map: a @1, b @2, c @3, product high byte @4, product low byte @5. No other addresses are touched.
- Reset (reset==0): state=LD_A, done=0, internal registers (A, B, C, ACC[15:0], MCAND[15:0], CNT[2:0]) = 0. Applies asynchronously.
- FSM after reset deassertion, one state per rising edge unless noted:
  - LD_A: A<=mem[1]
  - LD_B: B<=mem[2]
  - LD_C: C<=mem[3]; ACC<=0; MCAND<={8'b0,A}; CNT<=0
  - MUL1, 8 cycles, shift-add A*B over bits of B, LSB first:
    - if B[CNT], ACC<=ACC+MCAND
    - MCAND<<=1; CNT++
    - at CNT==7, go to MUL2 with MCAND<=ACC_next, ACC<=0, CNT<=0
  - MUL2, 8 cycles: same shift-add of the 16-bit MCAND by C. All sums truncated to 16 bits.
  - ST_HI: mem[4]<=ACC[15:8]
  - ST_LO: mem[5]<=ACC[7:0]
  - DONE: terminal; done=1; no further memory writes.
- Latency: done is high after the 21st rising edge following reset deassertion. done is registered and glitch-free.
- Arithmetic: result equals the low 16 bits of the unsigned a*b*c. Overflow is silently discarded in the base build.
- Reset mid-operation: abort immediately; the partial product is discarded. Memory locations 4/5 hold whatever was last written. A fresh run starts on deassertion using current mem[1..3].
- Operand changes to mem[1..3] after the respective LD state have no effect on the current run.
- Back-to-back runs: bench asserts reset, rewrites operands, deasserts. The previous result stays in mem[4..5] until overwritten at ST_HI/ST_LO.

Optional Feature:
- Macro MULT3_OVF_FLAG_EN.
- When defined:
  - Extra output port ovf (1 bit).
  - Additional 8-bit register OVX accumulates carries out of bit 15 during MUL1/MUL2, with bits shifted out of MCAND also tracked.
  - ovf is set at DONE if the true 24-bit product exceeds 0xFFFF; cleared by reset.
  - mem[6] is written with {7'b0,ovf} in one extra cycle after ST_LO, so done asserts at edge 22.
- When undefined: no ovf port, no mem[6] write, latency 21.

Decomposition:
- Package mult3_pkg:
  - address constants A_ADDR=1, B_ADDR=2, C_ADDR=3, PHI_ADDR=4, PLO_ADDR=5, OVF_ADDR=6
  - state enum state_t {LD_A, LD_B, LD_C, MUL1, MUL2, ST_HI, ST_LO, ST_OVF, DONE}
  - DW/AW defaults
- One sub-module: data_mem (instance dm1, array my_memory).
- The FSM and datapath stay in mult3_top.

Test Plan:
- mem[1..3]=2,3,4; release reset -> done at edge 21; mem[4]=0x00, mem[5]=0x18 (24).
- Assert reset, then mem[1..3]=12,14,4; release -> mem[4]=0x02, mem[5]=0xA0 (672); done low during reset, high again at edge 21.
- mem[1..3]=255,255,255 -> mem[4:5]=0x02FF (low 16 of 0xFD02FF); with MULT3_OVF_FLAG_EN, ovf=1 and mem[6]=0x01.
- mem[1..3]=0,200,77 -> mem[4:5]=0x0000; mem[1..3]=1,1,1 -> 0x0001.
- Drop reset low at edge 10 mid-MUL1 -> done=0 immediately, no write to mem[4..5]; after release, the correct product appears at edge 21.
- Check memory persistence: mem[1..3] and unrelated locations (e.g. mem[0], mem[7]) are unchanged after a run and after reset.

Source files
------------

// File: rtl/mult3_pkg.sv
// Shared constants and types for the mult3 engine: memory map, FSM states,
// default widths. Optional overflow flag build: MULT3_OVF_FLAG_EN.
package mult3_pkg;
  localparam int DW_DEF = 8;
  localparam int AW_DEF = 8;

  localparam int A_ADDR   = 1;
  localparam int B_ADDR   = 2;
  localparam int C_ADDR   = 3;
  localparam int PHI_ADDR = 4;
  localparam int PLO_ADDR = 5;
  localparam int OVF_ADDR = 6;

  typedef enum logic [3:0] {
    LD_A, LD_B, LD_C, MUL1, MUL2, ST_HI, ST_LO, ST_OVF, DONE
  } state_t;
endpackage

// File: rtl/mult3_if.sv
// Single-port memory bus between the engine (master) and data_mem (slave).
interface mult3_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output we, addr, wdata, input rdata);
  modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/mult3_data_mem.sv
// Data memory: combinational read, synchronous write, no reset so contents
// survive engine resets.
module data_mem #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input logic   clk,
  mult3_if.slave bus
);
  logic [DW-1:0] my_memory [2**AW];

  assign bus.rdata = my_memory[bus.addr];

  // write port
  always_ff @(posedge clk)
    if (bus.we) my_memory[bus.addr] <= bus.wdata;
endmodule

// File: rtl/mult3_top.sv
// mult3 engine: loads a,b,c from memory, computes a*b*c mod 2^(2*DW) with two
// shift-add passes, stores the product high/low bytes and raises done.
// Define MULT3_OVF_FLAG_EN for the ovf port and the extra mem[6] write.
module mult3_top
  import mult3_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic clk,
  input  logic reset,
`ifdef MULT3_OVF_FLAG_EN
  output logic ovf,
`endif
  output logic done
);
  localparam int PW = 2 * DW;

  mult3_if #(.DW(DW), .AW(AW)) bus ();
  data_mem #(.DW(DW), .AW(AW)) dm1 (.clk(clk), .bus(bus));

  state_t        state;
  logic [DW-1:0] a, b, c;
  logic [PW-1:0] acc, mcand, acc_nxt;
  logic [2:0]    cnt;
  logic          mul_bit;

  assign mul_bit = (state == MUL1) ? b[cnt] : c[cnt];

`ifdef MULT3_OVF_FLAG_EN
  // ovx/mcx extend acc/mcand upward so the full product is kept alongside
  // the truncated one; any bit left in ovx means the product overflowed.
  logic [DW-1:0] ovx, mcx, ovx_nxt;
  assign {ovx_nxt, acc_nxt} = {ovx, acc} + (mul_bit ? {mcx, mcand} : '0);
`else
  assign acc_nxt = acc + (mul_bit ? mcand : '0);
`endif

  // memory bus: address/write strobe follow the current state
  always_comb begin
    bus.we    = 1'b0;
    bus.addr  = AW'(A_ADDR);
    bus.wdata = acc[PW-1:DW];
    case (state)
      LD_B:   bus.addr = AW'(B_ADDR);
      LD_C:   bus.addr = AW'(C_ADDR);
      ST_HI:  begin bus.we = 1'b1; bus.addr = AW'(PHI_ADDR); end
      ST_LO:  begin bus.we = 1'b1; bus.addr = AW'(PLO_ADDR); bus.wdata = acc[DW-1:0]; end
`ifdef MULT3_OVF_FLAG_EN
      ST_OVF: begin bus.we = 1'b1; bus.addr = AW'(OVF_ADDR); bus.wdata = DW'(|ovx); end
`endif
      default: ;
    endcase
  end

  // sequencer and shift-add datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LD_A;
      done  <= 1'b0;
      a     <= '0;
      b     <= '0;
      c     <= '0;
      acc   <= '0;
      mcand <= '0;
      cnt   <= '0;
`ifdef MULT3_OVF_FLAG_EN
      ovx   <= '0;
      mcx   <= '0;
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        LD_A: begin a <= bus.rdata; state <= LD_B; end
        LD_B: begin b <= bus.rdata; state <= LD_C; end
        LD_C: begin
          c     <= bus.rdata;
          acc   <= '0;
          mcand <= PW'(a);
          cnt   <= '0;
`ifdef MULT3_OVF_FLAG_EN
          ovx   <= '0;
          mcx   <= '0;
`endif
          state <= MUL1;
        end
        MUL1, MUL2: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          cnt   <= cnt + 3'd1;
`ifdef MULT3_OVF_FLAG_EN
          ovx   <= ovx_nxt;
          {mcx, mcand} <= {mcx, mcand} << 1;
`endif
          if (cnt == 3'd7) begin
            cnt <= '0;
            if (state == MUL1) begin
              // a*b always fits in PW bits, so the extensions restart at 0
              mcand <= acc_nxt;
              acc   <= '0;
`ifdef MULT3_OVF_FLAG_EN
              mcx   <= '0;
              ovx   <= '0;
`endif
              state <= MUL2;
            end else begin
              state <= ST_HI;
            end
          end
        end
        ST_HI: state <= ST_LO;
`ifdef MULT3_OVF_FLAG_EN
        ST_LO: state <= ST_OVF;
        ST_OVF: begin
          ovf   <= |ovx;
          done  <= 1'b1;
          state <= DONE;
        end
`else
        ST_LO: begin
          done  <= 1'b1;
          state <= DONE;
        end
`endif
        DONE: ;
        default: state <= LD_A;
      endcase
    end
  end
endmodule

// File: tb/tb_mult3_top.sv
// Self-checking bench for mult3_top: directed spec cases, random operands,
// mid-run reset and memory persistence. Honours MULT3_OVF_FLAG_EN.
module tb_mult3_top;
`ifdef MULT3_OVF_FLAG_EN
  localparam int LAT = 22;
`else
  localparam int LAT = 21;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic done;
`ifdef MULT3_OVF_FLAG_EN
  logic ovf;
`endif

  int nvec = 0;
  int nerr = 0;
  logic [7:0] s0, s7;

  mult3_top #(.DW(8), .AW(8)) dut (
    .clk(clk),
    .reset(reset),
`ifdef MULT3_OVF_FLAG_EN
    .ovf(ovf),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  // product model: plain integer arithmetic on the operands
  function automatic int unsigned prod_full(input logic [7:0] a, b, c);
    return int'(a) * int'(b) * int'(c);
  endfunction

  task automatic load_ops(input logic [7:0] a, b, c);
    dut.dm1.my_memory[1] = a;
    dut.dm1.my_memory[2] = b;
    dut.dm1.my_memory[3] = c;
  endtask

  // one full run: reset, preload, release, check latency and stored result
  task automatic test_run(input logic [7:0] a, b, c, input string tag);
    int unsigned p;
    logic [15:0] exp16;
    logic [15:0] got;
    p = prod_full(a, b, c);
    exp16 = p[15:0];
    @(negedge clk); reset = 1'b0;
    #2;
    load_ops(a, b, c);
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL %s done_in_reset got=%b exp=0", tag, done); end
    @(negedge clk); reset = 1'b1;
    for (int e = 1; e <= LAT; e++) begin
      @(posedge clk); #1;
      if (e == LAT - 1) begin
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL %s done_early got=%b exp=0 edge=%0d", tag, done, e); end
      end
    end
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL %s done_at_lat got=%b exp=1", tag, done); end
    got = {dut.dm1.my_memory[4], dut.dm1.my_memory[5]};
    nvec++; if (got !== exp16) begin nerr++; $display("FAIL %s product a=%0d b=%0d c=%0d got=%h exp=%h", tag, a, b, c, got, exp16); end
`ifdef MULT3_OVF_FLAG_EN
    nvec++; if (ovf !== (p > 32'hFFFF)) begin nerr++; $display("FAIL %s ovf got=%b exp=%b", tag, ovf, (p > 32'hFFFF)); end
    nvec++; if (dut.dm1.my_memory[6] !== {7'b0, (p > 32'hFFFF)}) begin nerr++; $display("FAIL %s mem6 got=%h exp=%h", tag, dut.dm1.my_memory[6], {7'b0, (p > 32'hFFFF)}); end
`endif
    nvec++; if ({dut.dm1.my_memory[1], dut.dm1.my_memory[2], dut.dm1.my_memory[3]} !== {a, b, c}) begin
      nerr++; $display("FAIL %s operands_kept got=%h exp=%h", tag, {dut.dm1.my_memory[1], dut.dm1.my_memory[2], dut.dm1.my_memory[3]}, {a, b, c}); end
    // a few idle cycles in DONE must leave everything alone
    repeat (3) @(posedge clk); #1;
    nvec++; if (done !== 1'b1 || {dut.dm1.my_memory[4], dut.dm1.my_memory[5]} !== exp16) begin
      nerr++; $display("FAIL %s hold_done done=%b got=%h exp=%h", tag, done, {dut.dm1.my_memory[4], dut.dm1.my_memory[5]}, exp16); end
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b0;
    #1;
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got=%b exp=0", done); end
    nvec++; if (dut.state !== mult3_pkg::LD_A) begin nerr++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, mult3_pkg::LD_A); end
  endtask

  task automatic test_directed();
    test_run(8'd2, 8'd3, 8'd4, "dir_2_3_4");
    test_run(8'd12, 8'd14, 8'd4, "dir_12_14_4");
    test_run(8'd255, 8'd255, 8'd255, "dir_max");
    test_run(8'd0, 8'd200, 8'd77, "dir_zero");
    test_run(8'd1, 8'd1, 8'd1, "dir_ones");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      test_run(8'($urandom), 8'($urandom), 8'($urandom), "rand");
  endtask

  // async abort mid-MUL1, and async clear of done after a finished run
  task automatic test_mid_reset();
    logic [15:0] exp16;
    int unsigned p;
    @(negedge clk); reset = 1'b0;
    #2;
    load_ops(8'd37, 8'd91, 8'd203);
    dut.dm1.my_memory[4] = 8'hA5;
    dut.dm1.my_memory[5] = 8'h5A;
    @(negedge clk); reset = 1'b1;
    repeat (10) @(posedge clk);
    #2; reset = 1'b0;
    #1;
    nvec++; if (done !== 1'b0 || dut.state !== mult3_pkg::LD_A) begin nerr++; $display("FAIL mid_abort done=%b state=%0d exp done=0 state=0", done, dut.state); end
    repeat (15) @(posedge clk); #1;
    nvec++; if ({dut.dm1.my_memory[4], dut.dm1.my_memory[5]} !== 16'hA55A) begin
      nerr++; $display("FAIL mid_nowrite got=%h exp=a55a", {dut.dm1.my_memory[4], dut.dm1.my_memory[5]}); end
    p = prod_full(8'd37, 8'd91, 8'd203);
    exp16 = p[15:0];
    @(negedge clk); reset = 1'b1;
    for (int e = 1; e <= LAT; e++) begin
      @(posedge clk); #1;
      if (e == LAT - 1) begin
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL mid_rerun_early got=%b exp=0", done); end
      end
    end
    nvec++; if (done !== 1'b1 || {dut.dm1.my_memory[4], dut.dm1.my_memory[5]} !== exp16) begin
      nerr++; $display("FAIL mid_rerun done=%b got=%h exp=%h", done, {dut.dm1.my_memory[4], dut.dm1.my_memory[5]}, exp16); end
    #3; reset = 1'b0;
    #1;
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL async_clear got=%b exp=0", done); end
    nvec++; if ({dut.dm1.my_memory[4], dut.dm1.my_memory[5]} !== exp16) begin
      nerr++; $display("FAIL persist_after_reset got=%h exp=%h", {dut.dm1.my_memory[4], dut.dm1.my_memory[5]}, exp16); end
  endtask

  task automatic test_persistence();
    nvec++; if (dut.dm1.my_memory[0] !== s0 || dut.dm1.my_memory[7] !== s7) begin
      nerr++; $display("FAIL untouched m0=%h m7=%h exp m0=%h m7=%h", dut.dm1.my_memory[0], dut.dm1.my_memory[7], s0, s7); end
  endtask

  initial begin
    s0 = 8'($urandom);
    s7 = 8'($urandom);
    #1;
    dut.dm1.my_memory[0] = s0;
    dut.dm1.my_memory[7] = s7;
    test_reset();
    test_directed();
    test_random();
    test_mid_reset();
    test_persistence();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
